// File: rtl/hypot_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hypot_seq_ctrl
// Purpose  : Sequential floor(sqrt(x^2 + y^2)) using one shared shift-add
//            multiplier; optional fast root selected by HYPOT_FAST_ROOT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hypot_seq_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W:0]   result
);

  localparam int c_cw = $clog2(W + 1);
  localparam int c_aw = 2 * W + 2;
  localparam int c_sw = 2 * W + 1;
  localparam logic [c_cw-1:0] c_step_last_sq = c_cw'(W - 1);
  localparam logic [c_cw-1:0] c_bit_top      = c_cw'(W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQX  = 3'd1,
    S_SQY  = 3'd2,
    S_ROOT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t r_state, w_state_nxt;

  logic [W-1:0]    r_x, r_y;
  logic [c_aw-1:0] r_acc;
  logic [c_sw-1:0] r_sum;
  logic [c_cw-1:0] r_step, r_bit;
  logic [W:0]      r_root;
  logic [W:0]      r_result;
  logic            r_busy, r_done;

  logic [W:0]      w_opnd;
  logic [c_aw-1:0] w_pp, w_acc_nxt;
  logic [W:0]      w_root_nxt;
  logic            w_last_sq, w_root_last;

  assign w_last_sq = (r_step == c_step_last_sq);

`ifdef HYPOT_FAST_ROOT_EN
  // Digit-by-digit root: the accumulator doubles as the remainder.
  logic [c_aw-1:0] w_sum_pad, w_rem_sh, w_try;
  logic [c_cw:0]   w_pair_idx;
  logic            w_ge;

  assign w_sum_pad   = {1'b0, r_sum};
  assign w_pair_idx  = {r_bit, 1'b0};
  assign w_rem_sh    = {r_acc[c_aw-3:0], w_sum_pad[w_pair_idx +: 2]};
  assign w_try       = c_aw'({r_root, 2'b01});
  assign w_ge        = (w_rem_sh >= w_try);
  assign w_root_nxt  = {r_root[W-1:0], w_ge};
  assign w_root_last = (r_bit == '0);
`else
  localparam logic [W:0]      c_one           = 1;
  localparam logic [c_cw-1:0] c_step_last_trl = c_cw'(W);

  logic [W:0] w_trial;
  logic       w_fit;

  assign w_trial     = r_root | (c_one << r_bit);
  assign w_fit       = (w_acc_nxt <= {1'b0, r_sum});
  assign w_root_nxt  = w_fit ? w_trial : r_root;
  assign w_root_last = (r_step == c_step_last_trl) && (r_bit == '0);
`endif

  // Squaring only: multiplicand and multiplier are the same operand.
  always_comb begin
    w_opnd = '0;
    case (r_state)
      S_SQX:   w_opnd = {1'b0, r_x};
      S_SQY:   w_opnd = {1'b0, r_y};
`ifndef HYPOT_FAST_ROOT_EN
      S_ROOT:  w_opnd = w_trial;
`endif
      default: w_opnd = '0;
    endcase
    w_pp      = w_opnd[r_step] ? (c_aw'(w_opnd) << r_step) : '0;
    w_acc_nxt = r_acc + w_pp;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SQX;
      S_SQX:   if (w_last_sq) w_state_nxt = S_SQY;
      S_SQY:   if (w_last_sq) w_state_nxt = S_ROOT;
      S_ROOT:  if (w_root_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= '0;
      r_y      <= '0;
      r_acc    <= '0;
      r_sum    <= '0;
      r_step   <= '0;
      r_bit    <= '0;
      r_root   <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_SQX) || (w_state_nxt == S_SQY) ||
                (w_state_nxt == S_ROOT);
      r_done <= (w_state_nxt == S_FIN);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x    <= x;
            r_y    <= y;
            r_acc  <= '0;
            r_sum  <= '0;
            r_step <= '0;
            r_bit  <= c_bit_top;
            r_root <= '0;
          end
        end
        S_SQX, S_SQY: begin
          if (w_last_sq) begin
            r_step <= '0;
            r_acc  <= '0;
            if (r_state == S_SQX) r_sum <= c_sw'(w_acc_nxt);
            else                  r_sum <= r_sum + c_sw'(w_acc_nxt);
          end else begin
            r_step <= r_step + 1'b1;
            r_acc  <= w_acc_nxt;
          end
        end
        S_ROOT: begin
`ifdef HYPOT_FAST_ROOT_EN
          r_acc  <= w_ge ? (w_rem_sh - w_try) : w_rem_sh;
          r_root <= w_root_nxt;
          if (r_bit == '0) r_result <= w_root_nxt;
          else             r_bit    <= r_bit - 1'b1;
`else
          if (r_step == c_step_last_trl) begin
            r_step <= '0;
            r_acc  <= '0;
            r_root <= w_root_nxt;
            if (r_bit == '0) r_result <= w_root_nxt;
            else             r_bit    <= r_bit - 1'b1;
          end else begin
            r_step <= r_step + 1'b1;
            r_acc  <= w_acc_nxt;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_hypot_seq_ctrl.sv
`default_nettype none
// Self-checking bench for hypot_seq_ctrl: directed vector table plus
// multi-cycle handshake, reset and back-to-back sequences.
module tb_hypot_seq_ctrl;

`ifdef HYPOT_FAST_ROOT_EN
  localparam int L      = 25;
  localparam int RST_AT = 20;
`else
  localparam int L      = 97;
  localparam int RST_AT = 40;
`endif
  localparam int N_SWEEP = 300;

  logic       clk, rst_n, start;
  logic [7:0] x, y;
  logic       busy, done;
  logic [8:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  hypot_seq_ctrl #(.W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vx;
    logic [7:0] vy;
    logic [8:0] exp_r;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int isqrt(input int s);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < L + 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_one(input int idx, input logic [7:0] vx,
                         input logic [7:0] vy, input logic [8:0] exp_r);
    int  cyc;
    bit  busy_ok;
    x = vx; y = vy; start = 1'b1;
    tick();
    start = 1'b0;
    check($sformatf("vec%0d busy_at_accept", idx), busy, 1);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < L + 20) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
    check($sformatf("vec%0d latency", idx), cyc, L);
    check($sformatf("vec%0d result(%0d,%0d)", idx, vx, vy), result, exp_r);
    check($sformatf("vec%0d busy_at_fin", idx), busy, 0);
    check($sformatf("vec%0d busy_held", idx), busy_ok, 1);
    tick();
    check($sformatf("vec%0d done_fall", idx), done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pulses;
    logic [7:0] sx, sy, nx, ny;

    vecs[0]  = '{8'd3,   8'd4,   9'd5};
    vecs[1]  = '{8'd255, 8'd255, 9'd360};
    vecs[2]  = '{8'd0,   8'd0,   9'd0};
    vecs[3]  = '{8'd1,   8'd1,   9'd1};
    vecs[4]  = '{8'd0,   8'd200, 9'd200};
    vecs[5]  = '{8'd7,   8'd24,  9'd25};
    vecs[6]  = '{8'd200, 8'd0,   9'd200};
    vecs[7]  = '{8'd5,   8'd12,  9'd13};
    vecs[8]  = '{8'd255, 8'd0,   9'd255};
    vecs[9]  = '{8'd100, 8'd100, 9'd141};
    vecs[10] = '{8'd1,   8'd0,   9'd1};
    vecs[11] = '{8'd8,   8'd15,  9'd17};
    vecs[12] = '{8'd20,  8'd21,  9'd29};
    vecs[13] = '{8'd255, 8'd254, 9'd359};
    vecs[14] = '{8'd12,  8'd16,  9'd20};
    vecs[15] = '{8'd254, 8'd1,   9'd254};

    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    repeat (3) tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 16; i++)
      run_one(i, vecs[i].vx, vecs[i].vy, vecs[i].exp_r);

    // Extra start pulses mid-computation and during FIN are ignored.
    pulses = 0;
    x = 8'd3; y = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    x = 8'd6; y = 8'd8; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    if (done) pulses++;
    check("ignore latency", cyc + 10, L);
    check("ignore result", result, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ignore done_fall", done, 0);
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done) pulses++;
    end
    check("ignore done_pulses", pulses, 1);
    check("ignore result_hold", result, 5);
    check("ignore busy_idle", busy, 0);

    // Asynchronous reset in the middle of ROOT.
    x = 8'd3; y = 8'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (RST_AT) tick();
    check("midrst busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst result", result, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done) pulses++;
    end
    check("midrst no_done", pulses, 0);
    run_one(99, 8'd5, 8'd12, 9'd13);

    // Back-to-back with start held high.
    sx = 8'd255; sy = 8'd255;
    x = sx; y = sy; start = 1'b1;
    tick();
    for (int k = 0; k < N_SWEEP; k++) begin
      wait_done(cyc);
      if (k == 0) check("sweep first_latency", cyc, L);
      else        check($sformatf("sweep%0d interval", k), cyc + 1, L + 2);
      check($sformatf("sweep%0d result(%0d,%0d)", k, sx, sy), result,
            isqrt(int'(sx) * int'(sx) + int'(sy) * int'(sy)));
      nx = 8'($urandom_range(0, 255));
      ny = 8'($urandom_range(0, 255));
      x = nx; y = ny;
      tick();
      check($sformatf("sweep%0d done_width", k), done, 0);
      sx = nx; sy = ny;
    end
    start = 1'b0;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
